// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Imported by the loader top and its byte packer.
package imem_pkg;

  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_ADDR_W = 8;
  localparam int LEN_W       = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LEN_LO = ST_LEN_LO,
    S_LEN_HI = ST_LEN_HI,
    S_DATA   = ST_DATA,
    S_CHECK  = ST_CHECK,
    S_DONE   = ST_DONE,
    S_ERROR  = ST_ERROR
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words
// and keeps the running XOR checksum of every payload byte.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic [7:0]  xor_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  xor_q, xor_d;

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    xor_d  = xor_q;
    if (clr_i) begin
      lane_d = 2'd0;
      asm_d  = 24'd0;
      xor_d  = 8'd0;
    end else if (en_i) begin
      lane_d = lane_q + 2'd1;
      xor_d  = xor_q ^ byte_i;
      unique case (lane_q)
        2'd0:    asm_d[7:0]   = byte_i;
        2'd1:    asm_d[15:8]  = byte_i;
        2'd2:    asm_d[23:16] = byte_i;
        default: asm_d        = asm_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= 2'd0;
      asm_q  <= 24'd0;
      xor_q  <= 8'd0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
      xor_q  <= xor_d;
    end
  end

  // The 4th byte bypasses the assembly register straight into the word.
  assign word_valid_o = en_i && (lane_q == 2'd3);
  assign word_o       = {byte_i, asm_q};
  assign xor_o        = xor_q;

endmodule

// File: rtl/imem_program_loader.sv
// Byte-stream program loader driving the instruction memory write port;
// holds the core in reset until a checksum-valid image is written.
module imem_program_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W:0]    idx_q, idx_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [LEN_W-1:0]   n_hdr;
  logic               xfer, clr, pk_en;
  logic               word_valid;
  logic [31:0]        word;
  logic [7:0]         xor_sum;

  assign s_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                   (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer    = s_valid && s_ready;
  assign n_hdr   = {s_data, len_q[7:0]};

  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .en_i         (pk_en),
    .byte_i       (s_data),
    .word_valid_o (word_valid),
    .word_o       (word),
    .xor_o        (xor_sum)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    clr     = 1'b0;
    pk_en   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_LO;
          clr     = 1'b1;
          idx_d   = '0;
          len_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = {8'd0, s_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = n_hdr;
          if (n_hdr > LEN_W'(DEPTH))
            state_d = S_ERROR;
          else if (n_hdr == '0)
            state_d = S_CHECK;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        pk_en = xfer;
        if (word_valid) begin
          we_d    = 1'b1;
          waddr_d = idx_q[ADDR_W-1:0];
          wdata_d = word;
          idx_d   = idx_q + 1'b1;
          if (LEN_W'(idx_q) == len_q - 1'b1)
            state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer)
          state_d = (s_data == xor_sum) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cpu_hold  = (state_q != S_DONE);

endmodule
